// File: rtl/ahb_sram_master.sv
// ahb_sram_master: AHB-lite single-transfer master that turns a valid/ready command stream into pipelined NONSEQ transfers.
// Rev 1.0
`default_nettype none

module ahb_sram_master #(
  parameter int HADDR_W = 32,
  parameter int HDATA_W = 32
) (
  input  logic               hclk,
  input  logic               hresetn,
  // command / response stream
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [2:0]         cmd_size,
  input  logic [HADDR_W-1:0] cmd_addr,
  input  logic [HDATA_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [HDATA_W-1:0] rsp_rdata,
  // AHB-lite master side
  output logic               hsel,
  output logic               hwrite,
  output logic [1:0]         htrans,
  output logic [2:0]         hsize,
  output logic [HADDR_W-1:0] haddr,
  output logic [HDATA_W-1:0] hwdata,
  output logic               hready,
  input  logic [HDATA_W-1:0] hrdata,
  input  logic               hready_resp,
  input  logic [1:0]         hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_e;

  state_e state_q, state_d;

  // address stage
  logic               as_valid_q, as_valid_d;
  logic               as_write_q, as_write_d;
  logic [1:0]         as_size_q,  as_size_d;
  logic [HADDR_W-1:0] as_addr_q,  as_addr_d;
  logic [HDATA_W-1:0] as_wdata_q, as_wdata_d;

  // data stage
  logic               ds_valid_q, ds_valid_d;
  logic               ds_write_q, ds_write_d;
  logic [1:0]         ds_size_q,  ds_size_d;
  logic [1:0]         ds_lane_q,  ds_lane_d;
  logic [HDATA_W-1:0] ds_wdata_q, ds_wdata_d;

  // response
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q,   rsp_err_d;
  logic [HDATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic               w_run;
  logic               w_advance;
  logic               w_accept;
  logic               w_ds_done;
  logic               w_resp_err;
  logic [1:0]         w_cmd_size;
  logic [HADDR_W-1:0] w_cmd_addr;
  logic [HDATA_W-1:0] w_cmd_wdata;
  logic [HDATA_W-1:0] w_rd_data;

  assign w_run      = (state_q == ST_RUN);
  assign w_advance  = hready_resp & w_run;
  assign cmd_ready  = w_advance & hresetn;
  assign w_accept   = cmd_valid & cmd_ready;
  assign w_ds_done  = ds_valid_q & hready_resp;
  assign w_resp_err = (hresp == HRESP_ERROR);

  // Size normalisation, address alignment and write-lane replication on entry.
  always_comb begin
    w_cmd_size  = (cmd_size > 3'd2) ? 2'd2 : cmd_size[1:0];
    w_cmd_addr  = cmd_addr;
    w_cmd_wdata = cmd_wdata;
    case (w_cmd_size)
      2'd0: w_cmd_wdata = {4{cmd_wdata[7:0]}};
      2'd1: begin
        w_cmd_addr[0] = 1'b0;
        w_cmd_wdata   = {2{cmd_wdata[15:0]}};
      end
      default: w_cmd_addr[1:0] = 2'b00;
    endcase
  end

  always_comb begin
    case (ds_size_q)
      2'd0:    w_rd_data = {{(HDATA_W-8){1'b0}},  8'(hrdata >> {ds_lane_q, 3'b000})};
      2'd1:    w_rd_data = {{(HDATA_W-16){1'b0}}, 16'(hrdata >> {ds_lane_q[1], 4'b0000})};
      default: w_rd_data = hrdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    as_valid_d  = as_valid_q;
    as_write_d  = as_write_q;
    as_size_d   = as_size_q;
    as_addr_d   = as_addr_q;
    as_wdata_d  = as_wdata_q;
    ds_valid_d  = ds_valid_q;
    ds_write_d  = ds_write_q;
    ds_size_d   = ds_size_q;
    ds_lane_d   = ds_lane_q;
    ds_wdata_d  = ds_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    case (state_q)
      ST_RUN:  if (ds_valid_q && w_resp_err && !hready_resp) state_d = ST_ERR1;
      ST_ERR1: if (hready_resp) state_d = ST_ERR2;
      ST_ERR2: state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase

    if (w_ds_done) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = w_resp_err;
      rsp_rdata_d = (ds_write_q || w_resp_err) ? '0 : w_rd_data;
    end

    // During an error the AS entry is held so the cancelled transfer can be re-issued.
    if (w_advance) begin
      ds_valid_d = as_valid_q;
      ds_write_d = as_write_q;
      ds_size_d  = as_size_q;
      ds_lane_d  = as_addr_q[1:0];
      ds_wdata_d = as_wdata_q;
      as_valid_d = w_accept;
      if (w_accept) begin
        as_write_d = cmd_write;
        as_size_d  = w_cmd_size;
        as_addr_d  = w_cmd_addr;
        as_wdata_d = w_cmd_wdata;
      end
    end else if (w_ds_done) begin
      ds_valid_d = 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q     <= ST_RUN;
      as_valid_q  <= 1'b0;
      as_write_q  <= 1'b0;
      as_size_q   <= 2'd0;
      as_addr_q   <= '0;
      as_wdata_q  <= '0;
      ds_valid_q  <= 1'b0;
      ds_write_q  <= 1'b0;
      ds_size_q   <= 2'd0;
      ds_lane_q   <= 2'd0;
      ds_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      as_valid_q  <= as_valid_d;
      as_write_q  <= as_write_d;
      as_size_q   <= as_size_d;
      as_addr_q   <= as_addr_d;
      as_wdata_q  <= as_wdata_d;
      ds_valid_q  <= ds_valid_d;
      ds_write_q  <= ds_write_d;
      ds_size_q   <= ds_size_d;
      ds_lane_q   <= ds_lane_d;
      ds_wdata_q  <= ds_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign htrans    = (as_valid_q && w_run) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsel      = as_valid_q & w_run;
  assign hwrite    = as_write_q;
  assign hsize     = {1'b0, as_size_q};
  assign haddr     = as_addr_q;
  assign hwdata    = ds_wdata_q;
  assign hready    = hready_resp;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

`default_nettype wire

// File: doc/ahb_sram_master.md
Name: ahb_sram_master

Overview:
- AHB-lite single-transfer master that drives the SRAM controller slave port (hsel/hwrite/htrans/hsize/hready/haddr/hwdata in; hrdata/hready_resp/hresp out).
- Accepts a simple valid/ready command stream from test or firmware logic and converts it into pipelined NONSEQ transfers, with address phase N+1 overlapping data phase N.
- Performs byte-lane replication for writes and lane extraction for reads.
- Returns one response per command, with an error flag.

Parameters:
- HADDR_W, 32, width of haddr and cmd_addr
- HDATA_W, 32, width of hwdata/hrdata; fixed at 32, sizes byte/half/word only

Ports:
- hclk  in  1  AHB clock
- hresetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge hclk
- cmd_write  in  1  1 = write, 0 = read
- cmd_size  in  3  0 = byte, 1 = half, 2 = word; values >2 are treated as 2
- cmd_addr  in  HADDR_W  byte address
- cmd_wdata  in  32  write data, right-aligned
- rsp_valid  out  1  one-cycle pulse per completed command; no backpressure
- rsp_err  out  1  qualifies rsp_valid: slave returned ERROR
- rsp_rdata  out  32  read data, lane-extracted and zero-extended; 0 for writes
- hsel  out  1  slave select
- hwrite  out  1  AHB hwrite
- htrans  out  2  IDLE = 2'b00, NONSEQ = 2'b10 only
- hsize  out  3  AHB hsize
- haddr  out  HADDR_W  AHB address
- hwdata  out  32  AHB write data, data phase
- hready  out  1  hready to the slave, equal to hready_resp (single-slave system)
- hrdata  in  32  slave read data
- hready_resp  in  1  slave ready
- hresp  in  2  00 = OKAY, 01 = ERROR

Behaviour:
- Reset (asynchronous, hresetn low): clear all registers.
  - htrans = IDLE; hsel, hwrite, hsize, haddr, hwdata = 0.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - Pipeline stages empty; no response is ever produced for transfers in flight at reset.
- Two registered stages:
  - Address stage (AS): drives hsel/htrans/hwrite/hsize/haddr.
  - Data stage (DS): holds write flag, size, addr[1:0] and replicated wdata.
- Advance: the pipeline advances at a posedge when hready_resp = 1 and no error is in progress.
  - AS contents move to DS.
  - AS loads the accepted command, or becomes IDLE if none.
- cmd_ready = hready_resp & ~err_state & hresetn-deasserted. This gives back-to-back NONSEQ with zero idle cycles.
- Output encoding:
  - hsel = 1 exactly when htrans = NONSEQ.
  - haddr low bits are forced aligned: size 1 clears bit 0; size 2 clears bits [1:0].
- Write data: hwdata is driven from DS during the data phase and stays stable while hready_resp = 0.
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Read data:
  - Byte: hrdata >> (8*addr[1:0]) masked to 8 bits.
  - Half: hrdata >> (16*addr[1]) masked to 16 bits.
  - Word: hrdata.
- Completion: when DS is valid, hready_resp = 1 and hresp = OKAY, the next cycle has rsp_valid = 1 and rsp_err = 0. rsp_rdata is valid for reads and 0 for writes.
  - Latency: command accept to rsp_valid is 3 cycles with zero wait states, plus 1 per wait state.
- Error response (two-cycle ERROR):
  - Cycle 1 (hresp = 01, hready_resp = 0): enter err_state.
    - If AS holds a command, drive htrans = IDLE / hsel = 0 in the next cycle (cancel).
    - The cancelled command is retained internally.
  - Cycle 2 (hresp = 01, hready_resp = 1): DS completes.
    - Next cycle: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
    - Leave err_state; the retained command is re-issued as NONSEQ in the following cycle, before any new command is accepted.
- Ordering: responses are always returned in command order, exactly one per accepted command.
- Simultaneous events: a DS completion and an AS load in the same cycle are normal pipelining; both occur.
- hresp = ERROR with DS empty is ignored.
- FSM (error handling only): RUN, ERR1, ERR2.
  - RUN -> ERR1 on hresp = 01 & ~hready_resp.
  - ERR1 -> ERR2 on hready_resp.
  - ERR2 -> RUN unconditionally.

Test Plan:
- Reset then one word write: addr 0x10, wdata 0xA5A5_1234, zero wait -> htrans NONSEQ one cycle, hwdata 0xA5A5_1234 in the next cycle, rsp_valid 3 cycles after accept, rsp_err = 0.
- Byte write: addr 0x13, data 0x5C -> hsize 0, haddr 0x13, hwdata 0x5C5C_5C5C. Read back word at 0x10 -> rsp_rdata 0x5CA5_1234. Byte read at 0x13 -> 0x0000_005C.
- Four back-to-back word reads with cmd_valid held high -> four consecutive NONSEQ cycles, cmd_ready constant 1, four rsp_valid pulses in order.
- Slave inserts 2 wait states on a write -> hwdata stable for 3 cycles, next AS held, cmd_ready = 0 during waits, latency 5.
- ERROR on write at 0x20 with a read at 0x24 pending in AS -> htrans IDLE during ERR cycle 2, rsp_err = 1 for the write, read at 0x24 reissued then completes OK.
- hresetn pulsed low during a wait-stated read -> outputs return to reset values immediately, no rsp_valid for the in-flight read, normal operation after release.
